temporal_ngram_encoder: RTL

- Upstream producer for the three-modality associative memory.
- Accepts one spatially encoded hypervector per modality per sample.
- Keeps a sliding window of the last NGRAM_SIZE samples per modality and forms an N-gram by rotate-and-XOR binding.
- Presents the three N-gram hypervectors to the associative memory over a valid/ready handshake: this block's output side is the transmitter for the associative memory's input side.

---
 rtl/temporal_ngram_encoder_if.sv | 33 +++
 rtl/temporal_ngram_encoder.sv | 115 +++++++++++
 2 files changed

// File: rtl/temporal_ngram_encoder_if.sv
// Sample-in / N-gram-out handshake bundle for temporal_ngram_encoder.
// master = upstream producer plus downstream ready; slave = the encoder.
interface temporal_ngram_encoder_if #(
    parameter int unsigned HV_DIMENSION = 2000
);
    logic                    ValidIn_SI;
    logic                    FirstIn_SI;
    logic [0:HV_DIMENSION-1] HypervectorIn_mod1_DI;
    logic [0:HV_DIMENSION-1] HypervectorIn_mod2_DI;
    logic [0:HV_DIMENSION-1] HypervectorIn_mod3_DI;
    logic                    ReadyOut_SO;
    logic                    ValidOut_SO;
    logic                    ReadyIn_SI;
    logic [0:HV_DIMENSION-1] HypervectorOut_mod1_DO;
    logic [0:HV_DIMENSION-1] HypervectorOut_mod2_DO;
    logic [0:HV_DIMENSION-1] HypervectorOut_mod3_DO;

    modport master (
        output ValidIn_SI, FirstIn_SI,
        output HypervectorIn_mod1_DI, HypervectorIn_mod2_DI, HypervectorIn_mod3_DI,
        output ReadyIn_SI,
        input  ReadyOut_SO, ValidOut_SO,
        input  HypervectorOut_mod1_DO, HypervectorOut_mod2_DO, HypervectorOut_mod3_DO
    );

    modport slave (
        input  ValidIn_SI, FirstIn_SI,
        input  HypervectorIn_mod1_DI, HypervectorIn_mod2_DI, HypervectorIn_mod3_DI,
        input  ReadyIn_SI,
        output ReadyOut_SO, ValidOut_SO,
        output HypervectorOut_mod1_DO, HypervectorOut_mod2_DO, HypervectorOut_mod3_DO
    );
endinterface

// File: rtl/temporal_ngram_encoder.sv
// Sliding-window N-gram encoder: per modality keeps the last NGRAM_SIZE samples
// and emits XOR_i rho^i(hist[i]) to the associative memory over valid/ready.
module temporal_ngram_encoder #(
    parameter int unsigned HV_DIMENSION = 2000,
    parameter int unsigned NGRAM_SIZE   = 3,
    parameter int unsigned FILL_WIDTH   = $clog2(NGRAM_SIZE + 1)
) (
    input  logic                     Clk_CI,
    input  logic                     Reset_RI,
    temporal_ngram_encoder_if.slave  bus
);
    typedef logic [0:HV_DIMENSION-1] hv_t;
    typedef enum logic [1:0] {IDLE, ENCODE, OUTPUT_STABLE} state_t;

    state_t                state_q, state_d;
    logic [FILL_WIDTH-1:0] fill_q, fill_d;
    hv_t                   hist_q [3][NGRAM_SIZE];
    hv_t                   out_q  [3];
    hv_t                   in_vec [3];
    hv_t                   ngram  [3];
    logic                  accept, encode, ready, valid;

    // Bit 0 is leftmost, so rho (out[k] = in[k-1]) is a numeric right rotate.
    function automatic hv_t rho(input hv_t v, input int unsigned n);
        logic [0:2*HV_DIMENSION-1] dbl;
        dbl = {v, v} >> (n % HV_DIMENSION);
        return dbl[HV_DIMENSION +: HV_DIMENSION];
    endfunction

    always_comb begin
        in_vec[0] = bus.HypervectorIn_mod1_DI;
        in_vec[1] = bus.HypervectorIn_mod2_DI;
        in_vec[2] = bus.HypervectorIn_mod3_DI;
    end

    always_comb begin
        for (int unsigned m = 0; m < 3; m++) begin
            ngram[m] = '0;
            for (int unsigned i = 0; i < NGRAM_SIZE; i++) begin
                ngram[m] = ngram[m] ^ rho(hist_q[m][i], i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        ready   = 1'b0;
        valid   = 1'b0;
        accept  = 1'b0;
        encode  = 1'b0;
        case (state_q)
            IDLE: begin
                ready  = 1'b1;
                accept = bus.ValidIn_SI;
                if (accept) begin
                    if (bus.FirstIn_SI) begin
                        fill_d = FILL_WIDTH'(1);
                    end else if (fill_q < FILL_WIDTH'(NGRAM_SIZE)) begin
                        fill_d = fill_q + 1'b1;
                    end
                    if (fill_d == FILL_WIDTH'(NGRAM_SIZE)) begin
                        state_d = ENCODE;
                    end
                end
            end
            ENCODE: begin
                encode  = 1'b1;
                state_d = OUTPUT_STABLE;
            end
            OUTPUT_STABLE: begin
                valid = 1'b1;
                if (bus.ReadyIn_SI) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q <= IDLE;
            fill_q  <= '0;
            for (int unsigned m = 0; m < 3; m++) begin
                out_q[m] <= '0;
                for (int unsigned i = 0; i < NGRAM_SIZE; i++) begin
                    hist_q[m][i] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            for (int unsigned m = 0; m < 3; m++) begin
                if (accept) begin
                    hist_q[m][0] <= in_vec[m];
                    // A window-start sample flushes older history instead of shifting it.
                    for (int unsigned i = 1; i < NGRAM_SIZE; i++) begin
                        hist_q[m][i] <= bus.FirstIn_SI ? '0 : hist_q[m][i-1];
                    end
                end
                if (encode) begin
                    out_q[m] <= ngram[m];
                end
            end
        end
    end

    // Held low throughout reset even though the state register already sits in IDLE.
    assign bus.ReadyOut_SO            = ready & ~Reset_RI;
    assign bus.ValidOut_SO            = valid;
    assign bus.HypervectorOut_mod1_DO = out_q[0];
    assign bus.HypervectorOut_mod2_DO = out_q[1];
    assign bus.HypervectorOut_mod3_DO = out_q[2];
endmodule
